mc_core: RTL

MC_CORE -- requirements
Module: mc_core

---
 rtl/mc_core_pkg.sv | 122 ++++++++++++
 rtl/mc_core_if.sv | 30 +++
 rtl/mc_decode.sv | 61 ++++++
 rtl/mc_core.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// Shared types, opcode constants and datapath helper functions for the
// mc_core multi-cycle RV32I core.
package mc_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
    CL_BRANCH, CL_LOAD, CL_STORE, CL_ALU
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    alu_op_t      alu_op;
    logic         b_is_imm;
    logic [2:0]   funct3;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } ctrl_t;

  function automatic alu_op_t alu_sel(logic [2:0] f3, logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(logic [31:0] ir, imm_type_t t);
    case (t)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'd0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

  function automatic logic branch_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(logic [1:0] size, logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated across lanes; byte enables pick the target.
  function automatic logic [31:0] store_data(logic [1:0] size, logic [31:0] b);
    case (size)
      2'd0:    return {4{b[7:0]}};
      2'd1:    return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] rdata, logic [1:0] lo, logic [2:0] f3);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = rdata[{lo, 3'b000} +: 8];
    h16 = rdata[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    return {{24{b8[7]}}, b8};
      3'd1:    return {{16{h16[15]}}, h16};
      3'd4:    return {24'd0, b8};
      3'd5:    return {16'd0, h16};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mc_core_if.sv
// Instruction and data memory request/ack bus of mc_core; the core drives
// the master modport, memories the slave modport.
interface mc_core_if #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [3:0]         dmem_be;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               dmem_ack;
  logic [31:0]        dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR -> control bundle and sign-extended
// immediate. Anything outside the supported RV32I subset decodes as CL_ILLEGAL.
module mc_decode
  import mc_core_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic [31:0] imm
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_type_t  imm_type;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ctrl          = '0;
    ctrl.cls      = CL_ILLEGAL;
    ctrl.alu_op   = ALU_ADD;
    ctrl.funct3   = f3;
    ctrl.rd       = ir[11:7];
    ctrl.rs1      = ir[19:15];
    ctrl.rs2      = ir[24:20];
    imm_type      = IMM_I;
    case (opc)
      OPC_LUI:   begin ctrl.cls = CL_LUI;   imm_type = IMM_U; end
      OPC_AUIPC: begin ctrl.cls = CL_AUIPC; imm_type = IMM_U; end
      OPC_JAL:   begin ctrl.cls = CL_JAL;   imm_type = IMM_J; end
      OPC_JALR:  if (f3 == 3'd0) ctrl.cls = CL_JALR;
      OPC_BRANCH: begin
        imm_type = IMM_B;
        if (f3 != 3'd2 && f3 != 3'd3) ctrl.cls = CL_BRANCH;
      end
      OPC_LOAD:  if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ctrl.cls = CL_LOAD;
      OPC_STORE: begin
        imm_type = IMM_S;
        if (f3 inside {3'd0, 3'd1, 3'd2}) ctrl.cls = CL_STORE;
      end
      OPC_OPIMM: begin
        ctrl.b_is_imm = 1'b1;
        ctrl.alu_op   = alu_sel(f3, (f3 == 3'd5) && f7[5]);
        if ((f3 == 3'd1 && f7 == 7'h00) ||
            (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) ||
            (f3 != 3'd1 && f3 != 3'd5))
          ctrl.cls = CL_ALU;
      end
      OPC_OP: begin
        ctrl.alu_op = alu_sel(f3, f7[5]);
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
          ctrl.cls = CL_ALU;
      end
      default: ;
    endcase
    imm = imm_gen(ir, imm_type);
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencer, register file and PC.
// Optional MC_CORE_TRAP_EN: illegal instructions halt in TRAP instead of retiring as NOPs.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int          IMEM_AW  = 10,
  parameter int          DMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RSTn,
  mc_core_if.master bus,
  output logic  retire,
  output logic  trap
);
  state_t             state;
  logic [31:0]        pc, ir, a, b, imm_r, c;
  logic [31:0]        rf [32];
  logic [DMEM_AW-1:0] daddr_r;
  logic [3:0]         be_r;
  logic               we_r;
  logic [31:0]        wdata_r;

  ctrl_t       ctrl;
  logic [31:0] imm;
  logic [31:0] b_op, addr_sum;

  mc_decode u_decode (.ir(ir), .ctrl(ctrl), .imm(imm));

  assign b_op     = ctrl.b_is_imm ? imm_r : b;
  assign addr_sum = a + imm_r;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm_r   <= '0;
      c       <= '0;
      daddr_r <= '0;
      be_r    <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      // NOTE: the register file is cleared on reset; x0 is cleared but never written.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_ack) begin
          ir    <= bus.imem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= (ctrl.rs1 == 5'd0) ? '0 : rf[ctrl.rs1];
          b     <= (ctrl.rs2 == 5'd0) ? '0 : rf[ctrl.rs2];
          imm_r <= imm;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WB;
          case (ctrl.cls)
            CL_ALU:   c <= alu(ctrl.alu_op, a, b_op);
            CL_LUI:   c <= imm_r;
            CL_AUIPC: c <= pc + imm_r;
            CL_JAL: begin
              c  <= pc + 32'd4;
              pc <= pc + imm_r;
            end
            CL_JALR: begin
              c  <= pc + 32'd4;
              pc <= addr_sum & ~32'd1;
            end
            CL_BRANCH: begin
              pc    <= branch_taken(ctrl.funct3, a, b) ? pc + imm_r : pc + 32'd4;
              state <= S_FETCH;
            end
            CL_LOAD, CL_STORE: begin
              c       <= addr_sum;
              daddr_r <= addr_sum[DMEM_AW+1:2];
              we_r    <= (ctrl.cls == CL_STORE);
              be_r    <= (ctrl.cls == CL_STORE) ? store_be(ctrl.funct3[1:0], addr_sum[1:0])
                                                : 4'b1111;
              wdata_r <= store_data(ctrl.funct3[1:0], b);
              state   <= S_MEM;
            end
            default: begin
`ifdef MC_CORE_TRAP_EN
              state <= S_TRAP;
`endif
            end
          endcase
        end
        S_MEM: if (bus.dmem_ack) begin
          if (we_r) begin
            pc    <= pc + 32'd4;
            state <= S_FETCH;
          end else begin
            c     <= load_ext(bus.dmem_rdata, c[1:0], ctrl.funct3);
            state <= S_WB;
          end
        end
        S_WB: begin
          if (ctrl.cls != CL_ILLEGAL && ctrl.rd != 5'd0) rf[ctrl.rd] <= c;
          // Jumps already redirected the PC in EXEC.
          if (ctrl.cls != CL_JAL && ctrl.cls != CL_JALR) pc <= pc + 32'd4;
          state <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Fetch starts in the first cycle after reset release, so the request is
  // qualified with RSTn rather than waiting for a registered enable.
  assign bus.imem_req   = RSTn && (state == S_FETCH);
  assign bus.imem_addr  = pc[IMEM_AW+1:2];
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && we_r;
  assign bus.dmem_be    = (state == S_MEM) ? be_r : 4'b0000;
  assign bus.dmem_addr  = daddr_r;
  assign bus.dmem_wdata = wdata_r;

  assign retire = (state == S_WB) ||
                  (state == S_EXEC && ctrl.cls == CL_BRANCH) ||
                  (state == S_MEM && we_r && bus.dmem_ack);

`ifdef MC_CORE_TRAP_EN
  assign trap = (state == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
